note_lane_scheduler: RTL and testbench
======================================

// Module: note_lane_scheduler
// PURPOSE
//  Sequences the three falling-note lanes of the rhythm game: spawns notes from an LFSR pattern,
//  advances each active note's y on a fall tick, and judges key presses as hit/miss per lane.
//  Sits between main control (en_play) and the display/points blocks.
//  Drives lane y positions and activity flags to the renderer, and hit/miss pulses to scoring.
// PARAMETERS
//  TICK_DIV     9999990  clk_50 cycles per fall tick (tick period = TICK_DIV+1 cycles)
//  STEP         10       pixels added to each active lane y per tick
//  SPAWN_Y      50       y loaded into a lane on spawn
//  HIT_Y_LO     400      lowest y (inclusive) accepted as a hit
//  HIT_Y_HI     430      highest y (inclusive) accepted as a hit
//  MISS_Y       440      y at/after which an unhit note is retired as a miss
//  SPAWN_TICKS  8        ticks between spawn opportunities
//  SEED         16'hACE1 LFSR reset value (must be nonzero)
// PORTS
//  clk_50       in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  en_play      in   1   1 = RUN, 0 = IDLE (clears lanes)
//  key          in   3   lane keys, active-low, asynchronous (KEY[2:0])
//  tick         out  1   1-cycle pulse per fall tick
//  lane_active  out  3   bit i = lane i holds a live note
//  lane_y0      out  10  lane 0 note y (valid when lane_active[0])
//  lane_y1      out  10  lane 1 note y
//  lane_y2      out  10  lane 2 note y
//  hit_pulse    out  3   1-cycle pulse: lane i note hit
//  miss_pulse   out  3   1-cycle pulse: lane i note missed or bad press
// BEHAVIOUR
//  Reset: state=IDLE, tick=0, lane_active=0, lane_y*=SPAWN_Y, hit/miss=0, lfsr=SEED, counters=0.
//  FSM IDLE: divider, spawn count, lanes held cleared; en_play=1 -> RUN next cycle.
//  FSM RUN: en_play=0 -> IDLE next cycle; lanes clear, no pulses issued that cycle.
//  Divider: counts 0..TICK_DIV in RUN; tick=1 in the cycle count==TICK_DIV, then wraps to 0.
//  Tick actions, same edge: every active lane y += STEP (10-bit, saturate at 1023).
//  Miss on tick: an active lane whose new y >= MISS_Y clears and pulses miss_pulse[i] next cycle.
//  Spawn: spawn counter counts ticks; on the tick where it reaches SPAWN_TICKS-1 it wraps to 0.
//  Spawn lane: LFSR (x^16+x^14+x^13+x^11, shift-left, fb into bit0) steps once.
//  Spawn decode: lane = new lfsr[1:0]; 0..2 selects lane, 3 = rest (no spawn).
//  Spawn into an active lane is dropped: no overwrite, no pulse.
//  Spawned lane: active=1, y=SPAWN_Y; not moved by that same tick.
//  Keys: 2-flop synchronizer per bit, then falling-edge detect (press = sync 1->0).
//  Press latency: hit/miss pulse 3 cycles after the pin falls.
//  Press judgement, lane i, RUN only: active and HIT_Y_LO<=y<=HIT_Y_HI -> hit, lane cleared.
//  Press on an active lane outside the window, or on an empty lane -> miss_pulse[i], lane unchanged.
//  Held keys do not repeat; presses in IDLE are ignored.
//  Same cycle press and tick on lane i: press judged on pre-tick y.
//   If hit: lane clears, no move, no tick-miss.
//  Same cycle press and spawn on lane i: spawn dropped if lane still active after judgement.
//  Lanes independent: multiple bits of hit_pulse/miss_pulse may assert together.
//  hit_pulse[i] and miss_pulse[i] never both 1.
//  Reset mid-RUN: all outputs return to reset values on the next edge; synchronizers clear to 1.
// TESTING
//  Bench parameters: TICK_DIV=3, STEP=10, SPAWN_TICKS=2; others default.
//  Tick: en_play=1 -> tick every 4 cycles, first tick 4 cycles after RUN entry.
//   en_play=0 -> no ticks, lane_active=0.
//  Fall/miss: force spawn lane0 (y=50), no key press.
//   y steps 60,70,...,430 then 440 -> lane0 clears, miss_pulse=3'b001 for 1 cycle.
//  Hit: lane1 at y=420, key[1] driven 1->0 -> hit_pulse=3'b010 exactly 3 cycles later.
//   lane_active[1]=0; holding key low gives no further pulse.
//  Bad press: lane2 at y=200 pressed -> miss_pulse=3'b100, lane2 stays active at y=200.
//   Empty-lane press -> miss_pulse only.
//  Collision: lane0 active and spawn decode=0 -> lane0 y keeps advancing, not reloaded.
//   Press lane0 at y=430 on a tick cycle -> hit, no miss.
//  Reset: rst=1 mid-RUN with lanes active -> next cycle lane_active=0.
//   All lane_y=50, lfsr=SEED: spawn sequence repeats identically.

Source files
------------

// File: rtl/note_lane_scheduler_if.sv
// Bundle between main control / renderer / scoring and the note lane scheduler.
interface note_lane_scheduler_if;
    logic       en_play;
    logic [2:0] key;
    logic       tick;
    logic [2:0] lane_active;
    logic [9:0] lane_y0;
    logic [9:0] lane_y1;
    logic [9:0] lane_y2;
    logic [2:0] hit_pulse;
    logic [2:0] miss_pulse;

    modport master (
        output en_play, key,
        input  tick, lane_active, lane_y0, lane_y1, lane_y2, hit_pulse, miss_pulse
    );
    modport slave (
        input  en_play, key,
        output tick, lane_active, lane_y0, lane_y1, lane_y2, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/note_lane_scheduler.sv
// Three-lane falling-note sequencer: fall-tick divider, LFSR spawner,
// key synchronisers and per-lane hit/miss judgement.
module note_lane_scheduler #(
    parameter int unsigned TICK_DIV    = 9999990,
    parameter int unsigned STEP        = 10,
    parameter int unsigned SPAWN_Y     = 50,
    parameter int unsigned HIT_Y_LO    = 400,
    parameter int unsigned HIT_Y_HI    = 430,
    parameter int unsigned MISS_Y      = 440,
    parameter int unsigned SPAWN_TICKS = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  clk_50,
    input  logic                  rst,
    note_lane_scheduler_if.slave  bus
);
    localparam int NUM_LANES = 3;
    localparam int DIV_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int SPC_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV);
    localparam logic [SPC_W-1:0] SPC_LAST = SPC_W'(SPAWN_TICKS - 1);
    localparam logic [9:0]  Y_SPAWN  = 10'(SPAWN_Y);
    localparam logic [9:0]  Y_HIT_LO = 10'(HIT_Y_LO);
    localparam logic [9:0]  Y_HIT_HI = 10'(HIT_Y_HI);
    localparam logic [9:0]  Y_MISS   = 10'(MISS_Y);
    localparam logic [10:0] Y_STEP   = 11'(STEP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state;
    logic [DIV_W-1:0]           div_cnt, div_nxt;
    logic [SPC_W-1:0]           spawn_cnt;
    logic [15:0]                lfsr, lfsr_nxt;
    logic [NUM_LANES-1:0]       key_s1, key_s2, key_s3;
    logic                       tick_r;
    logic [NUM_LANES-1:0]       active, act_nxt;
    logic [NUM_LANES-1:0]       hit_r, miss_r, hit_c, miss_c;
    logic [NUM_LANES-1:0]       spawn_sel, press;
    logic [NUM_LANES-1:0][9:0]  lane_y, y_nxt;
    logic                       fire, spawn_fire;

    assign fire       = (state == RUN) && bus.en_play && (div_cnt == DIV_LAST);
    assign div_nxt    = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    assign spawn_fire = fire && (spawn_cnt == SPC_LAST);
    assign lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign press      = key_s3 & ~key_s2;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [10:0] y_sum;
        logic [9:0]  y_mv;
        logic        in_win, alive, retire, spawn_take;

        assign spawn_sel[i] = spawn_fire && (lfsr_nxt[1:0] == 2'(i));
        assign in_win       = (lane_y[i] >= Y_HIT_LO) && (lane_y[i] <= Y_HIT_HI);
        assign hit_c[i]     = press[i] && active[i] && in_win;
        // Judgement uses the pre-tick y; a hit lane is gone before the move.
        assign alive        = active[i] && !hit_c[i];
        assign y_sum        = {1'b0, lane_y[i]} + Y_STEP;
        assign y_mv         = y_sum[10] ? 10'h3FF : y_sum[9:0];
        assign retire       = fire && alive && (y_mv >= Y_MISS);
        assign spawn_take   = spawn_sel[i] && !alive;
        assign miss_c[i]    = (press[i] && !hit_c[i]) || retire;
        assign act_nxt[i]   = spawn_take || (alive && !retire);
        assign y_nxt[i]     = spawn_take     ? Y_SPAWN :
                              (fire && alive) ? y_mv    : lane_y[i];
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            spawn_cnt <= '0;
            lfsr      <= SEED;
            key_s1    <= '1;
            key_s2    <= '1;
            key_s3    <= '1;
            tick_r    <= 1'b0;
            active    <= '0;
            lane_y    <= {NUM_LANES{Y_SPAWN}};
            hit_r     <= '0;
            miss_r    <= '0;
        end else begin
            key_s1 <= bus.key;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
            hit_r  <= '0;
            miss_r <= '0;
            tick_r <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt   <= '0;
                    spawn_cnt <= '0;
                    active    <= '0;
                    lane_y    <= {NUM_LANES{Y_SPAWN}};
                    if (bus.en_play) begin
                        state  <= RUN;
                        tick_r <= (DIV_LAST == '0);
                    end
                end
                RUN: begin
                    if (!bus.en_play) begin
                        state     <= IDLE;
                        div_cnt   <= '0;
                        spawn_cnt <= '0;
                        active    <= '0;
                        lane_y    <= {NUM_LANES{Y_SPAWN}};
                    end else begin
                        div_cnt <= div_nxt;
                        tick_r  <= (div_nxt == DIV_LAST);
                        if (fire)
                            spawn_cnt <= spawn_fire ? '0 : spawn_cnt + SPC_W'(1);
                        if (spawn_fire)
                            lfsr <= lfsr_nxt;
                        active <= act_nxt;
                        lane_y <= y_nxt;
                        hit_r  <= hit_c;
                        miss_r <= miss_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tick        = tick_r;
    assign bus.lane_active = active;
    assign bus.lane_y0     = lane_y[0];
    assign bus.lane_y1     = lane_y[1];
    assign bus.lane_y2     = lane_y[2];
    assign bus.hit_pulse   = hit_r;
    assign bus.miss_pulse  = miss_r;
endmodule

// File: tb/tb_note_lane_scheduler.sv
// Randomised bench for note_lane_scheduler: a rule-level lane model feeds a
// per-cycle expectation queue that a separate monitor drains and compares.
module tb_note_lane_scheduler;
    localparam int TD      = 3;
    localparam int STEP    = 10;
    localparam int SPAWN_Y = 50;
    localparam int HIT_LO  = 400;
    localparam int HIT_HI  = 430;
    localparam int MISS_Y  = 440;
    localparam int ST      = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic            tick;
        logic [2:0]      act;
        logic [2:0][9:0] y;
        logic [2:0]      hit;
        logic [2:0]      miss;
    } exp_t;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;
    note_lane_scheduler_if bus();

    note_lane_scheduler #(.TICK_DIV(TD), .STEP(STEP), .SPAWN_TICKS(ST)) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: cycles since RUN entry and ticks since RUN entry
    // stand in for the divider and spawn counter.
    bit          m_run = 0;
    int          m_r = 0, m_nt = 0;
    logic [15:0] m_lfsr = SEED;
    logic [2:0]  m_act = '0, m_hit = '0, m_miss = '0;
    int          m_y[3] = '{SPAWN_Y, SPAWN_Y, SPAWN_Y};
    logic [2:0]  k1 = '1, k2 = '1, k3 = '1;

    initial forever begin
        logic [2:0] press;
        bit         tk, spawn_ok;
        int         sl;
        exp_t       e;
        @(posedge clk_50);
        tk    = m_run && (m_r % (TD + 1) == TD);
        press = k3 & ~k2;
        k3 = k2; k2 = k1; k1 = bus.key;
        m_hit = '0; m_miss = '0;
        if (rst) begin
            m_run = 0; m_r = 0; m_nt = 0; m_lfsr = SEED; m_act = '0;
            k1 = '1; k2 = '1; k3 = '1;
            for (int i = 0; i < 3; i++) m_y[i] = SPAWN_Y;
        end else if (!m_run || !bus.en_play) begin
            m_run = !m_run && bus.en_play;
            m_r = 0; m_nt = 0; m_act = '0;
            for (int i = 0; i < 3; i++) m_y[i] = SPAWN_Y;
        end else begin
            for (int i = 0; i < 3; i++)
                if (press[i]) begin
                    if (m_act[i] && m_y[i] >= HIT_LO && m_y[i] <= HIT_HI) begin
                        m_act[i] = 1'b0; m_hit[i] = 1'b1;
                    end else m_miss[i] = 1'b1;
                end
            if (tk) begin
                m_nt++;
                sl = 3;
                if (m_nt % ST == 0) begin
                    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
                    sl = int'(m_lfsr[1:0]);
                end
                spawn_ok = (sl < 3) && !m_act[sl];
                for (int i = 0; i < 3; i++)
                    if (m_act[i]) begin
                        m_y[i] = (m_y[i] + STEP > 1023) ? 1023 : m_y[i] + STEP;
                        if (m_y[i] >= MISS_Y) begin m_act[i] = 1'b0; m_miss[i] = 1'b1; end
                    end
                if (spawn_ok) begin m_act[sl] = 1'b1; m_y[sl] = SPAWN_Y; end
            end
            m_r++;
        end
        e.tick = m_run && (m_r % (TD + 1) == TD);
        e.act  = m_act;
        for (int i = 0; i < 3; i++) e.y[i] = 10'(m_y[i]);
        e.hit  = m_hit;
        e.miss = m_miss;
        exp_q.push_back(e);
    end

    initial forever begin
        exp_t       e;
        logic [9:0] dy[3];
        @(negedge clk_50);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            dy[0] = bus.lane_y0; dy[1] = bus.lane_y1; dy[2] = bus.lane_y2;
            chk("tick", 32'(bus.tick), 32'(e.tick));
            chk("lane_active", 32'(bus.lane_active), 32'(e.act));
            for (int i = 0; i < 3; i++)
                if (e.act[i]) chk("lane_y", 32'(dy[i]), 32'(e.y[i]));
            chk("hit_pulse", 32'(bus.hit_pulse), 32'(e.hit));
            chk("miss_pulse", 32'(bus.miss_pulse), 32'(e.miss));
            chk("hit_and_miss", 32'(bus.hit_pulse & bus.miss_pulse), 32'(0));
        end
    end

    task automatic run_cycles(input int n, input int rate);
        logic [2:0] kv;
        for (int c = 0; c < n; c++) begin
            @(posedge clk_50); #1;
            kv = bus.key;
            for (int i = 0; i < 3; i++) begin
                if (!kv[i]) begin
                    if ($urandom_range(2) == 0) kv[i] = 1'b1;
                end else if ((m_act[i] && m_y[i] >= HIT_LO - STEP && m_y[i] <= HIT_HI
                              && $urandom_range(3) == 0) || $urandom_range(rate - 1) == 0)
                    kv[i] = 1'b0;
            end
            bus.key = kv;
        end
    endtask

    initial begin
        bus.en_play = 1'b0;
        bus.key     = 3'b111;
        rst         = 1'b1;
        repeat (3) @(posedge clk_50);
        #1;
        chk("reset_active", 32'(bus.lane_active), 32'(0));
        chk("reset_tick", 32'(bus.tick), 32'(0));
        chk("reset_y0", 32'(bus.lane_y0), 32'(SPAWN_Y));
        chk("reset_y2", 32'(bus.lane_y2), 32'(SPAWN_Y));
        chk("reset_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 32'(0));
        rst = 1'b0;
        run_cycles(12, 6);
        bus.en_play = 1'b1;
        run_cycles(600, 40);
        bus.en_play = 1'b0;
        run_cycles(15, 8);
        bus.en_play = 1'b1;
        run_cycles(400, 25);
        @(posedge clk_50); #1 rst = 1'b1;
        @(posedge clk_50); #1;
        chk("midrun_reset_active", 32'(bus.lane_active), 32'(0));
        chk("midrun_reset_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 32'(0));
        rst = 1'b0;
        run_cycles(500, 30);
        repeat (4) begin
            bus.en_play = 1'b1;
            run_cycles(150 + int'($urandom_range(99)), 20);
            bus.en_play = 1'b0;
            run_cycles(1 + int'($urandom_range(3)), 10);
        end
        repeat (3) @(negedge clk_50);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
